sr_latch_monitor: RTL and testbench

//  Clocked checker on the far side of an SR latch: samples the latch inputs S/R and outputs Q/Qbar.

---
 rtl/sr_mon_pkg.sv | 35 +++
 rtl/sr_mon_sat_cnt.sv | 35 +++
 rtl/sr_latch_monitor.sv | 140 ++++++++++++++
 tb/tb_sr_latch_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_mon_pkg.sv
// Shared encodings for the SR latch monitor: FSM states, error codes and the
// {s,r} input patterns, plus the latch next-state decode.
package sr_mon_pkg;

  typedef enum logic [1:0] {
    UNK_ST  = 2'd0,
    SET_ST  = 2'd1,
    RST_ST  = 2'd2,
    FORB_ST = 2'd3
  } mon_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_COMPL    = 2'd2;
  localparam logic [1:0] ERR_RACE     = 2'd3;

  // {s,r} patterns, active-high latch convention
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_FORB = 2'b11;

  function automatic mon_state_e next_state(input mon_state_e cur, input logic [1:0] sr);
    mon_state_e nxt;
    case (sr)
      SR_SET:  nxt = SET_ST;
      SR_RST:  nxt = RST_ST;
      SR_FORB: nxt = FORB_ST;
      SR_HOLD: nxt = (cur == FORB_ST) ? UNK_ST : cur;
      default: nxt = UNK_ST;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all ones once reached.
module sr_mon_sat_cnt
  import sr_mon_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear wins, then increment unless already saturated
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sr_latch_monitor.sv
// Clocked SR latch checker: tracks the expected latch state, flags Q mismatch,
// Q==Qbar and (when SR_MON_RACE_FLAG_EN is defined) the 11->00 race.
module sr_latch_monitor
  import sr_mon_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qbar,
  output logic             exp_q,
  output logic             exp_valid,
  output logic [1:0]       state,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] evt_count
);

  localparam int SET_W = 4;
  localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE);

  mon_state_e       state_q,     state_d;
  logic [1:0]       sr_prev_q,   sr_prev_d;
  logic [SET_W-1:0] settle_q,    settle_d;
  logic             exp_q_q,     exp_q_d;
  logic             exp_valid_q, exp_valid_d;
  logic             err_valid_q, err_valid_d;
  logic [1:0]       err_code_q,  err_code_d;
  logic             reported_q,  reported_d;

  logic [1:0] sr_s;
  logic       sr_chg_s;
  logic       check_en_s;
  logic       mismatch_s;
  logic       compl_s;
  logic       viol_s;
  logic       fire_chk_s;
  logic       race_s;
  logic       evt_s;

  assign sr_s       = {s, r};
  assign sr_chg_s   = (sr_s != sr_prev_q);
  assign check_en_s = (settle_q == {SET_W{1'b0}});
  assign mismatch_s = ((state_q == SET_ST) && !q) || ((state_q == RST_ST) && q);
  assign compl_s    = (state_q != FORB_ST) && (q == qbar);
  assign viol_s     = mismatch_s || compl_s;
  assign fire_chk_s = check_en_s && viol_s && !reported_q;

`ifdef SR_MON_RACE_FLAG_EN
  assign race_s = (sr_prev_q == SR_FORB) && (sr_s == SR_HOLD);
`else
  assign race_s = 1'b0;
`endif

  // next-state, settle window, one-shot reporting and error outputs
  always_comb begin
    state_d     = next_state(state_q, sr_s);
    sr_prev_d   = sr_s;
    exp_q_d     = (state_d == SET_ST);
    exp_valid_d = (state_d == SET_ST) || (state_d == RST_ST);
    evt_s       = exp_valid_d && (state_d != state_q);

    if (sr_chg_s) begin
      settle_d = SETTLE_LD;
    end else if (!check_en_s) begin
      settle_d = settle_q - SET_W'(1);
    end else begin
      settle_d = settle_q;
    end

    // a fault stays quiet until the inputs change or the latch looks consistent again
    if (sr_chg_s) begin
      reported_d = 1'b0;
    end else if (fire_chk_s) begin
      reported_d = 1'b1;
    end else if (check_en_s && !viol_s) begin
      reported_d = 1'b0;
    end else begin
      reported_d = reported_q;
    end

    err_valid_d = fire_chk_s || race_s;
    if (fire_chk_s) begin
      err_code_d = mismatch_s ? ERR_MISMATCH : ERR_COMPL;
    end else if (race_s) begin
      err_code_d = ERR_RACE;
    end else begin
      err_code_d = err_code_q;
    end
  end

  // state and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UNK_ST;
      sr_prev_q   <= SR_HOLD;
      settle_q    <= {SET_W{1'b0}};
      exp_q_q     <= 1'b0;
      exp_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      reported_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_prev_q   <= sr_prev_d;
      settle_q    <= settle_d;
      exp_q_q     <= exp_q_d;
      exp_valid_q <= exp_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      reported_q  <= reported_d;
    end
  end

  sr_mon_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .clr   (!rst_n),
    .inc   (err_valid_d),
    .count (err_count)
  );

  sr_mon_sat_cnt #(.W(CNT_W)) u_evt_cnt (
    .clk   (clk),
    .clr   (!rst_n),
    .inc   (evt_s),
    .count (evt_count)
  );

  assign state     = state_q;
  assign exp_q     = exp_q_q;
  assign exp_valid = exp_valid_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Scoreboard bench for sr_latch_monitor: directed scenarios then randomized
// latch behaviour with injected faults, checked against a behavioural model.
`timescale 1ns/1ps
module tb_sr_latch_monitor;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;
`ifdef SR_MON_RACE_FLAG_EN
  localparam bit RACE_EN = 1'b1;
`else
  localparam bit RACE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s = 1'b0, r = 1'b1, q = 1'b0, qbar = 1'b1;
  logic exp_q, exp_valid, err_valid;
  logic [1:0] state, err_code;
  logic [CNT_W-1:0] err_count, evt_count;
  logic exp_q2, exp_valid2, err_valid2;
  logic [1:0] state2, err_code2;
  logic [CNT_W2-1:0] err_count2, evt_count2;

  sr_latch_monitor #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q), .qbar(qbar),
    .exp_q(exp_q), .exp_valid(exp_valid), .state(state), .err_valid(err_valid),
    .err_code(err_code), .err_count(err_count), .evt_count(evt_count));

  sr_latch_monitor #(.SETTLE(SETTLE), .CNT_W(CNT_W2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s(s), .r(r), .q(q), .qbar(qbar),
    .exp_q(exp_q2), .exp_valid(exp_valid2), .state(state2), .err_valid(err_valid2),
    .err_code(err_code2), .err_count(err_count2), .evt_count(evt_count2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int code;
    int errs;
    int cyc;
  } ev_t;
  ev_t evq[$];

  // reference model: 0=unknown 1=set 2=reset 3=forbidden
  int m_state, m_last_sr, m_since, m_code, m_errs, m_evts;
  bit m_rep;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit rst_l, input int sr, input bit qv, input bit qbv);
    bit chk, mis, cmp, fire, race;
    int nxt;
    ev_t e;
    if (!rst_l) begin
      m_state = 0; m_last_sr = 0; m_since = SETTLE; m_rep = 1'b0;
      m_code = 0; m_errs = 0; m_evts = 0;
      return;
    end
    chk  = (m_since >= SETTLE);
    mis  = (m_state == 1 && !qv) || (m_state == 2 && qv);
    cmp  = (m_state != 3) && (qv == qbv);
    race = RACE_EN && (m_last_sr == 3) && (sr == 0);
    fire = chk && (mis || cmp) && !m_rep;
    if (sr != m_last_sr) begin
      m_rep = 1'b0;
      m_since = 0;
    end else begin
      if (fire) m_rep = 1'b1;
      else if (chk && !(mis || cmp)) m_rep = 1'b0;
      if (m_since < 1000) m_since++;
    end
    case (sr)
      2: nxt = 1;
      1: nxt = 2;
      3: nxt = 3;
      default: nxt = (m_state == 3) ? 0 : m_state;
    endcase
    if ((nxt == 1 || nxt == 2) && nxt != m_state) m_evts++;
    if (fire || race) begin
      m_errs++;
      m_code = fire ? (mis ? 1 : 2) : 3;
      e.code = m_code;
      e.errs = m_errs;
      e.cyc  = cyc + 1;
      evq.push_back(e);
    end
    m_state = nxt;
    m_last_sr = sr;
  endtask

  task automatic check_outputs();
    check("state", state, m_state);
    check("exp_q", exp_q, (m_state == 1));
    check("exp_valid", exp_valid, (m_state == 1 || m_state == 2));
    check("err_code", err_code, m_code);
    check("err_count", err_count, sat(m_errs, CNT_W));
    check("evt_count", evt_count, sat(m_evts, CNT_W));
    check("err_count_w2", err_count2, sat(m_errs, CNT_W2));
    check("evt_count_w2", evt_count2, sat(m_evts, CNT_W2));
  endtask

  task automatic cycle(input bit rst_l, input bit sv, input bit rv, input bit qv, input bit qbv);
    @(negedge clk);
    check_outputs();
    rst_n = rst_l; s = sv; r = rv; q = qv; qbar = qbv;
    model_step(rst_l, {30'd0, sv, rv}, qv, qbv);
  endtask

  task automatic hold(input int n, input bit rst_l, input bit sv, input bit rv, input bit qv, input bit qbv);
    for (int i = 0; i < n; i++) cycle(rst_l, sv, rv, qv, qbv);
  endtask

  // monitor: pops one expected event per err_valid pulse
  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (err_valid === 1'b1) begin
        if (evq.size() == 0) begin
          check("ev_spurious", err_valid, 1'b0);
        end else begin
          e = evq.pop_front();
          check("ev_code", err_code, e.code);
          check("ev_errs", err_count, sat(e.errs, CNT_W));
          check("ev_cycle", cyc, e.cyc);
        end
      end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        e = evq.pop_front();
        check("ev_missing", err_valid, 1'b1);
      end
    end
  end

  initial begin
    int sr, len, fault, prev_sr;
    bit do_rst, lq, lqb, qv, qbv;

    model_step(1'b0, 1, 1'b0, 1'b1);
    @(negedge clk);
    mon_on = 1'b1;

    // 1: reset with 01, then reset state held
    hold(3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    hold(4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_state", state, 2);
    check("t1_evt", evt_count, 1);
    // 2: set, latch follows two cycles later
    hold(2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    hold(4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_evt", evt_count, 2);
    // 3: back to reset, then set with q stuck low
    hold(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    hold(4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    hold(8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3_errs", err_count, 1);
    check("t3_code", err_code, 1);
    // 4: forbidden with q=qbar=0, then direct release to 00
    hold(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    hold(4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    hold(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // 5: hold in SET with q==qbar
    hold(5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    hold(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    // 6: repeated mismatches saturate the narrow counter, then reset mid-settle
    for (int i = 0; i < 5; i++) begin
      hold(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      hold(5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    check("t6_sat", err_count2, 3);
    hold(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    hold(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("t6_rst_state", state, 0);
    check("t6_rst_errs", err_count, 0);
    check("t6_rst_code", err_code, 0);
    hold(3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // randomized latch with lag of one cycle, occasional faults and resets
    prev_sr = 1; lq = 1'b0; lqb = 1'b1;
    for (int p = 0; p < 300; p++) begin
      sr     = $urandom_range(0, 3);
      len    = $urandom_range(1, 6);
      fault  = $urandom_range(0, 9);
      do_rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < len; k++) begin
        case (prev_sr)
          2: begin lq = 1'b1; lqb = 1'b0; end
          1: begin lq = 1'b0; lqb = 1'b1; end
          3: begin lq = 1'b0; lqb = 1'b0; end
          default: if (lq == lqb) begin lq = 1'($urandom_range(0, 1)); lqb = !lq; end
        endcase
        qv = lq; qbv = lqb;
        if (fault == 0) qv = !qv;
        else if (fault == 1) qbv = qv;
        cycle(!(do_rst && k == 0), sr[1], sr[0], qv, qbv);
        prev_sr = sr;
      end
    end

    hold(8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("ev_queue_empty", evq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
